// File: rtl/nx_msg_arbiter_if.sv
// Handshake bundle between the two requesting message streams, the arbiter
// and the shared outbound Nexus message stream.
interface nx_msg_arbiter_if #(
    parameter int DATA_W = 31
);
    logic [DATA_W-1:0] i_a_data;
    logic              i_a_valid;
    logic              o_a_ready;
    logic [DATA_W-1:0] i_b_data;
    logic              i_b_valid;
    logic              o_b_ready;
    logic [DATA_W:0]   o_ob_data;
    logic              o_ob_valid;
    logic              i_ob_ready;
    logic [1:0]        o_grant;
    logic              o_idle;

    modport master (
        output i_a_data, i_a_valid, i_b_data, i_b_valid, i_ob_ready,
        input  o_a_ready, o_b_ready, o_ob_data, o_ob_valid, o_grant, o_idle
    );

    modport slave (
        input  i_a_data, i_a_valid, i_b_data, i_b_valid, i_ob_ready,
        output o_a_ready, o_b_ready, o_ob_data, o_ob_valid, o_grant, o_idle
    );
endinterface

// File: rtl/nx_msg_arbiter.sv
// Two-way round-robin message arbiter with bounded bursts and one registered
// output stage; each outbound message carries its source tag in the MSB.
module nx_msg_arbiter #(
    parameter int DATA_W    = 31,
    parameter int MAX_BURST = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    nx_msg_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GNT_A = 2'd1;
    localparam logic [1:0] S_GNT_B = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;        // 0 = A served last, 1 = B
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ob_valid_q, ob_valid_d;
    logic [DATA_W:0]  ob_data_q, ob_data_d;

    logic       slot;
    logic       a_ready, b_ready;
    logic       acc_a, acc_b, accept;
    logic       is_b, own_v, oth_v;
    logic [1:0] other_st;

    assign slot    = !ob_valid_q || bus.i_ob_ready;
    assign a_ready = (state_q == S_GNT_A) && slot;
    assign b_ready = (state_q == S_GNT_B) && slot;
    assign acc_a   = a_ready && bus.i_a_valid;
    assign acc_b   = b_ready && bus.i_b_valid;
    assign accept  = acc_a || acc_b;

    // Granted-side view, meaningful only in GNT_A / GNT_B.
    assign is_b     = (state_q == S_GNT_B);
    assign own_v    = is_b ? bus.i_b_valid : bus.i_a_valid;
    assign oth_v    = is_b ? bus.i_a_valid : bus.i_b_valid;
    assign other_st = is_b ? S_GNT_A : S_GNT_B;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.i_a_valid && bus.i_b_valid) begin
                    state_d = last_q ? S_GNT_A : S_GNT_B;
                end else if (bus.i_a_valid) begin
                    state_d = S_GNT_A;
                end else if (bus.i_b_valid) begin
                    state_d = S_GNT_B;
                end
            end
            S_GNT_A, S_GNT_B: begin
                if (accept) begin
                    if (cnt_q == CNT_LAST) begin
                        // Burst limit: hand over only if the other side waits.
                        cnt_d = '0;
                        if (oth_v) begin
                            state_d = other_st;
                            last_d  = is_b;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (!own_v) begin
                    cnt_d   = '0;
                    last_d  = is_b;
                    state_d = oth_v ? other_st : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        ob_valid_d = ob_valid_q;
        ob_data_d  = ob_data_q;
        if (accept) begin
            ob_valid_d = 1'b1;
            ob_data_d  = acc_b ? {1'b1, bus.i_b_data} : {1'b0, bus.i_a_data};
        end else if (bus.i_ob_ready) begin
            ob_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            ob_valid_q <= 1'b0;
            ob_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            ob_valid_q <= ob_valid_d;
            ob_data_q  <= ob_data_d;
        end
    end

    assign bus.o_a_ready  = a_ready;
    assign bus.o_b_ready  = b_ready;
    assign bus.o_ob_valid = ob_valid_q;
    assign bus.o_ob_data  = ob_data_q;
    assign bus.o_grant    = {state_q == S_GNT_B, state_q == S_GNT_A};
    assign bus.o_idle     = (state_q == S_IDLE) && !ob_valid_q;
endmodule
